// File: rtl/quadrature_decoder.sv
// Quadrature decoder: synchronises asynchronous A/B phases, decodes each Gray edge
// into a signed step and accumulates a wrapping position count with a sticky error flag.
module quadrature_decoder #(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clock_in,
  input  logic                   reset,
  input  logic                   quad_a,
  input  logic                   quad_b,
  input  logic                   clear,
  output logic [COUNT_WIDTH-1:0] count_out,
  output logic                   direction,
  output logic                   step,
  output logic                   error
);

  typedef enum logic {
    S_FILL = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam logic signed [COUNT_WIDTH-1:0] C_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

  state_t r_state;
  state_t w_state_nxt;
  logic [1:0] r_fill_cnt;

  logic [1:0] r_ab_p0;
  logic [1:0] r_ab_p1;
  logic [1:0] r_ab_prev;

  logic w_fill_done;
  logic w_fwd;
  logic w_rev;
  logic w_illegal;

  logic signed [COUNT_WIDTH-1:0] r_count_p2;
  logic                          r_dir_p2;
  logic                          r_step_vld_p2;
  logic                          r_err_p2;

  function automatic logic signed [COUNT_WIDTH-1:0] f_wrap_step(
    input logic signed [COUNT_WIDTH-1:0] cnt,
    input logic                          fwd,
    input logic                          rev
  );
    logic signed [COUNT_WIDTH-1:0] res;
    res = cnt;
    if (fwd) begin
      res = cnt + C_ONE;
    end else if (rev) begin
      res = cnt - C_ONE;
    end
    return res;
  endfunction

  // Stage p0/p1: two-flop synchroniser, then the previous accepted sample
  always_ff @(posedge clock_in) begin
    if (reset) begin
      r_ab_p0   <= 2'b00;
      r_ab_p1   <= 2'b00;
      r_ab_prev <= 2'b00;
    end else begin
      r_ab_p0 <= {quad_a, quad_b};
      r_ab_p1 <= r_ab_p0;
      if ((r_state == S_RUN) || w_fill_done) begin
        r_ab_prev <= r_ab_p1;
      end
    end
  end

  assign w_fill_done = (r_state == S_FILL) && (r_fill_cnt == 2'd2);

  always_ff @(posedge clock_in) begin
    if (reset) begin
      r_state    <= S_FILL;
      r_fill_cnt <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == S_FILL) && !w_fill_done) begin
        r_fill_cnt <= r_fill_cnt + 2'd1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_FILL:  if (w_fill_done) w_state_nxt = S_RUN;
      S_RUN:   w_state_nxt = S_RUN;
      default: w_state_nxt = S_FILL;
    endcase
  end

  // Edge classification on {prev, current}; only meaningful once the history is primed
  always_comb begin
    w_fwd     = 1'b0;
    w_rev     = 1'b0;
    w_illegal = 1'b0;
    if (r_state == S_RUN) begin
      case ({r_ab_prev, r_ab_p1})
        4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: w_fwd     = 1'b1;
        4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: w_rev     = 1'b1;
        4'b00_11, 4'b11_00, 4'b10_01, 4'b01_10: w_illegal = 1'b1;
        default: ;
      endcase
    end
  end

  // Stage p2: registered count, direction, step pulse and sticky error
  always_ff @(posedge clock_in) begin
    if (reset) begin
      r_count_p2    <= '0;
      r_dir_p2      <= 1'b0;
      r_step_vld_p2 <= 1'b0;
      r_err_p2      <= 1'b0;
    end else begin
      r_step_vld_p2 <= w_fwd | w_rev;
      if (w_fwd | w_rev) begin
        r_dir_p2 <= w_fwd;
      end
      if (clear) begin
        r_count_p2 <= '0;
        r_err_p2   <= 1'b0;
      end else begin
        r_count_p2 <= f_wrap_step(r_count_p2, w_fwd, w_rev);
        if (w_illegal) begin
          r_err_p2 <= 1'b1;
        end
      end
    end
  end

  assign count_out = r_count_p2;
  assign direction = r_dir_p2;
  assign step      = r_step_vld_p2;
  assign error     = r_err_p2;

endmodule
